// File: rtl/pcma_pkg.sv
// Shared definitions for the PCMA lock supervisor: mode encodings, mask bit
// positions, supervisor state type and the hypothesis-selection helpers.
package pcma_pkg;

  localparam int unsigned MODE_W = 3;
  localparam int unsigned MASK_W = 2;

  localparam logic [MODE_W-1:0] MODE_NONE = 3'b000;
  localparam logic [MODE_W-1:0] MODE_FM4  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_FM8  = 3'b010;

  localparam int unsigned MASK_FM4 = 0;
  localparam int unsigned MASK_FM8 = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_HUNT,
    ST_LOCKED
  } state_e;

  // First allowed hypothesis, fm4 preferred.
  function automatic logic [MODE_W-1:0] first_mode(input logic [MASK_W-1:0] mask);
    if (mask[MASK_FM4]) begin
      return MODE_FM4;
    end else if (mask[MASK_FM8]) begin
      return MODE_FM8;
    end else begin
      return MODE_NONE;
    end
  endfunction

  // Next hypothesis in the fm4 -> fm8 -> fm4 ring, skipping masked modes.
  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] cur,
                                                  input logic [MASK_W-1:0] mask);
    if (cur == MODE_FM4) begin
      if (mask[MASK_FM8]) begin
        return MODE_FM8;
      end else if (mask[MASK_FM4]) begin
        return MODE_FM4;
      end else begin
        return MODE_NONE;
      end
    end else begin
      return first_mode(mask);
    end
  endfunction

endpackage

// File: rtl/pcma_lock_supervisor_counter.sv
// Saturating verdict counter with clear, increment and a combinational flag
// that fires on the increment which reaches the threshold.
module pcma_verdict_counter #(
  parameter int unsigned THRESH = 3,
  parameter int unsigned CNT_W  = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit_c
);

  localparam logic [CNT_W-1:0] C_MAX    = '1;
  localparam logic [CNT_W-1:0] C_THRESH = CNT_W'(THRESH);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_inc_val;

  assign w_inc_val = (r_count == C_MAX) ? r_count : r_count + CNT_W'(1);
  assign o_hit_c   = i_inc && !i_clr && (w_inc_val >= C_THRESH);

  // Clear wins over increment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= w_inc_val;
    end
  end

endmodule

// File: rtl/pcma_lock_supervisor.sv
// PCMA lock supervisor: hypothesis sequencing, detector flush, verdict
// hysteresis and watchdog. Optional statistics under PCMA_SUP_STATS_EN.
module pcma_lock_supervisor
  import pcma_pkg::*;
#(
  parameter int unsigned CONFIRM_CNT   = 3,
  parameter int unsigned LOSS_CNT      = 4,
  parameter int unsigned HUNT_TRIES    = 2,
  parameter int unsigned FLUSH_CYCLES  = 8,
  parameter int unsigned TIMEOUT_WIDTH = 20,
  parameter int unsigned CNT_WIDTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en_i,
  input  logic [MASK_W-1:0]        mode_mask_i,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_i,
  input  logic                     det_done_i,
  input  logic                     det_lock_i,
  output logic [MODE_W-1:0]        det_mode_o,
  output logic                     det_rst_n_o,
  output logic                     locked_o,
  output logic [MODE_W-1:0]        locked_mode_o,
  output logic                     busy_o
`ifdef PCMA_SUP_STATS_EN
  ,
  output logic [15:0]              loss_cnt_o,
  output logic [15:0]              hunt_cycles_o
`endif
);

  localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  state_e                   r_state,       w_state_nxt;
  logic [MODE_W-1:0]        r_det_mode,    w_det_mode_nxt;
  logic                     r_det_rst_n,   w_det_rst_n_nxt;
  logic                     r_locked,      w_locked_nxt;
  logic [MODE_W-1:0]        r_locked_mode, w_locked_mode_nxt;
  logic                     r_busy,        w_busy_nxt;
  logic [FLUSH_W-1:0]       r_flush_cnt,   w_flush_cnt_nxt;
  logic [TIMEOUT_WIDTH-1:0] r_wd,          w_wd_nxt;

  logic w_run;
  logic w_active;
  logic w_expire;
  logic w_lock_v;
  logic w_miss_v;
  logic w_in_hunt;
  logic w_in_locked;
  logic w_confirm_hit;
  logic w_miss_hit;
  logic w_loss_hit;
  logic w_advance;

  // A zero mask is handled exactly like a disable.
  assign w_run       = en_i && (mode_mask_i != '0);
  assign w_in_hunt   = w_run && (r_state == ST_HUNT);
  assign w_in_locked = w_run && (r_state == ST_LOCKED);
  assign w_active    = w_in_hunt || w_in_locked;

  // Watchdog expiry is a synthetic no-lock verdict; a real done pulse wins.
  assign w_expire = w_active && (timeout_i != '0) && !det_done_i &&
                    (r_wd >= timeout_i - TIMEOUT_WIDTH'(1));
  assign w_lock_v = w_active && det_done_i && det_lock_i;
  assign w_miss_v = w_active && ((det_done_i && !det_lock_i) || w_expire);

  pcma_verdict_counter #(.THRESH(CONFIRM_CNT), .CNT_W(CNT_WIDTH)) u_confirm (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (!w_in_hunt || w_miss_v),
    .i_inc   (w_in_hunt && w_lock_v),
    .o_hit_c (w_confirm_hit)
  );

  pcma_verdict_counter #(.THRESH(HUNT_TRIES), .CNT_W(CNT_WIDTH)) u_miss (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (!w_in_hunt || w_lock_v),
    .i_inc   (w_in_hunt && w_miss_v),
    .o_hit_c (w_miss_hit)
  );

  pcma_verdict_counter #(.THRESH(LOSS_CNT), .CNT_W(CNT_WIDTH)) u_loss (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (!w_in_locked || w_lock_v),
    .i_inc   (w_in_locked && w_miss_v),
    .o_hit_c (w_loss_hit)
  );

  always_comb begin
    w_wd_nxt = '0;
    if (w_active && !det_done_i && !w_expire && (r_wd != '1)) begin
      w_wd_nxt = r_wd + TIMEOUT_WIDTH'(1);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_det_mode_nxt    = r_det_mode;
    w_det_rst_n_nxt   = r_det_rst_n;
    w_locked_nxt      = r_locked;
    w_locked_mode_nxt = r_locked_mode;
    w_flush_cnt_nxt   = r_flush_cnt;
    w_advance         = 1'b0;

    if (!w_run) begin
      w_state_nxt       = ST_IDLE;
      w_det_mode_nxt    = MODE_NONE;
      w_det_rst_n_nxt   = 1'b0;
      w_locked_nxt      = 1'b0;
      w_locked_mode_nxt = MODE_NONE;
      w_flush_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt     = ST_FLUSH;
          w_det_mode_nxt  = first_mode(mode_mask_i);
          w_det_rst_n_nxt = 1'b0;
          w_flush_cnt_nxt = '0;
        end
        ST_FLUSH: begin
          if (r_flush_cnt == FLUSH_LAST) begin
            w_state_nxt     = ST_HUNT;
            w_det_rst_n_nxt = 1'b1;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt + FLUSH_W'(1);
          end
        end
        ST_HUNT: begin
          if (w_confirm_hit) begin
            w_state_nxt       = ST_LOCKED;
            w_locked_nxt      = 1'b1;
            w_locked_mode_nxt = r_det_mode;
          end else if (w_miss_hit) begin
            w_advance = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_loss_hit) begin
            w_locked_nxt      = 1'b0;
            w_locked_mode_nxt = MODE_NONE;
            w_advance         = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase

      if (w_advance) begin
        w_state_nxt     = ST_FLUSH;
        w_det_mode_nxt  = next_mode(r_det_mode, mode_mask_i);
        w_det_rst_n_nxt = 1'b0;
        w_flush_cnt_nxt = '0;
      end
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_det_mode    <= MODE_NONE;
      r_det_rst_n   <= 1'b0;
      r_locked      <= 1'b0;
      r_locked_mode <= MODE_NONE;
      r_busy        <= 1'b0;
      r_flush_cnt   <= '0;
      r_wd          <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_det_mode    <= w_det_mode_nxt;
      r_det_rst_n   <= w_det_rst_n_nxt;
      r_locked      <= w_locked_nxt;
      r_locked_mode <= w_locked_mode_nxt;
      r_busy        <= w_busy_nxt;
      r_flush_cnt   <= w_flush_cnt_nxt;
      r_wd          <= w_wd_nxt;
    end
  end

  assign det_mode_o    = r_det_mode;
  assign det_rst_n_o   = r_det_rst_n;
  assign locked_o      = r_locked;
  assign locked_mode_o = r_locked_mode;
  assign busy_o        = r_busy;

`ifdef PCMA_SUP_STATS_EN
  logic [15:0] r_loss_cnt;
  logic [15:0] r_hunt_cycles;
  logic        w_loss_evt;
  logic        w_hunt_adv;

  assign w_loss_evt = w_in_locked && w_loss_hit;
  assign w_hunt_adv = w_in_hunt && w_miss_hit && !w_confirm_hit;

  // Saturating event statistics; only reset clears them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_loss_cnt    <= '0;
      r_hunt_cycles <= '0;
    end else begin
      if (w_loss_evt && (r_loss_cnt != 16'hFFFF)) begin
        r_loss_cnt <= r_loss_cnt + 16'd1;
      end
      if (w_hunt_adv && (r_hunt_cycles != 16'hFFFF)) begin
        r_hunt_cycles <= r_hunt_cycles + 16'd1;
      end
    end
  end

  assign loss_cnt_o    = r_loss_cnt;
  assign hunt_cycles_o = r_hunt_cycles;
`endif

endmodule

// File: tb/tb_pcma_lock_supervisor.sv
// Self-checking bench for pcma_lock_supervisor: directed test-plan steps plus a
// randomized phase, all checked against a cycle-level behavioural model.
module tb_pcma_lock_supervisor;

  localparam int CONFIRM = 3;
  localparam int LOSS    = 4;
  localparam int TRIES   = 2;
  localparam int FLUSH   = 8;
  localparam int TW      = 20;

  logic          clk;
  logic          reset_n;
  logic          en;
  logic [1:0]    mode_mask;
  logic [TW-1:0] timeout;
  logic          done;
  logic          lock;
  logic [2:0]    det_mode;
  logic          det_rst_n;
  logic          locked;
  logic [2:0]    locked_mode;
  logic          busy;
`ifdef PCMA_SUP_STATS_EN
  logic [15:0]   loss_cnt;
  logic [15:0]   hunt_cycles;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Model state: plain flags and integer streak counts.
  bit m_active, m_rstn, m_locked;
  int m_mode, m_lmode, m_flush_left, m_hits, m_misses, m_losses, m_wd;

  pcma_lock_supervisor dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .en_i          (en),
    .mode_mask_i   (mode_mask),
    .timeout_i     (timeout),
    .det_done_i    (done),
    .det_lock_i    (lock),
    .det_mode_o    (det_mode),
    .det_rst_n_o   (det_rst_n),
    .locked_o      (locked),
    .locked_mode_o (locked_mode),
    .busy_o        (busy)
`ifdef PCMA_SUP_STATS_EN
    ,
    .loss_cnt_o    (loss_cnt),
    .hunt_cycles_o (hunt_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_next(input int cur, input logic [1:0] mask);
    int order[2];
    int idx;
    int cand;
    order[0] = 1;
    order[1] = 2;
    idx = (cur == 2) ? 1 : 0;
    for (int k = 1; k <= 2; k++) begin
      cand = order[(idx + k) % 2];
      if ((cand == 1 && mask[0]) || (cand == 2 && mask[1])) return cand;
    end
    return 0;
  endfunction

  task automatic model_clear();
    m_active = 0; m_rstn = 0; m_locked = 0; m_mode = 0; m_lmode = 0;
    m_flush_left = 0; m_hits = 0; m_misses = 0; m_losses = 0; m_wd = 0;
  endtask

  task automatic model_flush_to(input int mode);
    m_mode = mode; m_flush_left = FLUSH; m_rstn = 0;
    m_hits = 0; m_misses = 0; m_losses = 0; m_wd = 0;
  endtask

  // One clock of the supervisor rules, using the inputs present at the edge.
  task automatic model_step();
    int verdict;
    if (!reset_n || !en || mode_mask == 2'b00) begin
      model_clear();
    end else if (!m_active) begin
      m_active = 1;
      model_flush_to(mode_mask[0] ? 1 : 2);
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      if (m_flush_left == 0) begin
        m_rstn = 1; m_hits = 0; m_misses = 0; m_losses = 0; m_wd = 0;
      end
    end else begin
      verdict = -1;
      if (done) verdict = lock ? 1 : 0;
      else if (timeout != 0 && m_wd + 1 >= int'(timeout)) verdict = 0;
      m_wd = (verdict >= 0) ? 0 : m_wd + 1;
      if (!m_locked) begin
        if (verdict == 1) begin
          m_misses = 0; m_hits++;
          if (m_hits >= CONFIRM) begin
            m_locked = 1; m_lmode = m_mode; m_hits = 0;
          end
        end else if (verdict == 0) begin
          m_hits = 0; m_misses++;
          if (m_misses >= TRIES) model_flush_to(model_next(m_mode, mode_mask));
        end
      end else begin
        if (verdict == 1) begin
          m_losses = 0;
        end else if (verdict == 0) begin
          m_losses++;
          if (m_losses >= LOSS) begin
            m_locked = 0; m_lmode = 0;
            model_flush_to(model_next(m_mode, mode_mask));
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] model_vec();
    return 32'({3'(m_mode), m_rstn, m_locked, 3'(m_lmode), m_active});
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model", 32'({det_mode, det_rst_n, locked, locked_mode, busy}), model_vec());
  endtask

  task automatic pulse(input logic l);
    done = 1'b1;
    lock = l;
    tick();
    done = 1'b0;
    lock = 1'b0;
  endtask

  // Ticks until det_rst_n_o reaches level (bounded); returns ticks taken.
  task automatic wait_rstn(input logic level, input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (det_rst_n !== level && n < max);
  endtask

  initial begin
    int n;
    int quality;
    model_clear();
    reset_n = 1'b0; en = 1'b0; mode_mask = 2'b00; timeout = '0; done = 1'b0; lock = 1'b0;
    repeat (3) tick();
    chk("reset_vec", 32'({det_mode, det_rst_n, locked, locked_mode, busy}), 32'd0);
    reset_n = 1'b1;
    tick();

    // Lock on fm4
    mode_mask = 2'b11; en = 1'b1;
    tick();
    chk("fm4_flush_mode", 32'(det_mode), 32'd1);
    chk("fm4_flush_rstn", 32'(det_rst_n), 32'd0);
    chk("fm4_busy", 32'(busy), 32'd1);
    wait_rstn(1'b1, 20, n);
    chk("flush_len", 32'(n), 32'd8);
    pulse(1'b1); tick();
    pulse(1'b1); tick();
    chk("pre_lock", 32'(locked), 32'd0);
    pulse(1'b1);
    chk("lock_fm4", 32'(locked), 32'd1);
    chk("lock_fm4_mode", 32'(locked_mode), 32'd1);
    tick();

    // Disable while locked
    en = 1'b0;
    tick();
    chk("disable_vec", 32'({det_mode, det_rst_n, locked, locked_mode, busy}), 32'd0);
    en = 1'b1;

    // Hunt advance fm4 -> fm8 -> fm4
    tick();
    wait_rstn(1'b1, 20, n);
    pulse(1'b0); tick();
    pulse(1'b0);
    chk("adv_fm8", 32'(det_mode), 32'd2);
    chk("adv_flush", 32'(det_rst_n), 32'd0);
    wait_rstn(1'b1, 20, n);
    pulse(1'b0); tick();
    pulse(1'b0);
    chk("adv_fm4", 32'(det_mode), 32'd1);

    // Single mode fm8
    en = 1'b0; tick();
    mode_mask = 2'b10; en = 1'b1;
    tick();
    chk("single_first", 32'(det_mode), 32'd2);
    for (int i = 0; i < 3; i++) begin
      wait_rstn(1'b1, 20, n);
      pulse(1'b0); tick();
      pulse(1'b0);
      chk("single_reselect", 32'(det_mode), 32'd2);
    end
    wait_rstn(1'b1, 20, n);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1); tick();
    end
    chk("lock_fm8", 32'({locked, locked_mode}), 32'({1'b1, 3'd2}));

    // Loss hysteresis
    mode_mask = 2'b11;
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0); tick();
    end
    pulse(1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0);
      chk("loss_hold", 32'(locked), 32'd1);
      tick();
    end
    pulse(1'b0);
    chk("loss_drop", 32'({locked, locked_mode}), 32'd0);
    chk("loss_mode", 32'(det_mode), 32'd1);
    chk("loss_flush", 32'(det_rst_n), 32'd0);

    // Watchdog
    timeout = TW'(100);
    wait_rstn(1'b1, 20, n);
    wait_rstn(1'b0, 300, n);
    chk("wd_flush_at", 32'(n), 32'd200);
    chk("wd_mode", 32'(det_mode), 32'd2);
    timeout = '0;
    wait_rstn(1'b1, 20, n);
    repeat (500) tick();
    chk("wd_off_hunt", 32'({det_rst_n, busy}), 32'b11);

    // Reset in HUNT
    reset_n = 1'b0;
    tick();
    chk("reset_mid", 32'({det_mode, det_rst_n, locked, locked_mode, busy}), 32'd0);
    reset_n = 1'b1;

    // Randomized operation
    quality = 50;
    mode_mask = 2'b11; en = 1'b1; timeout = TW'(20);
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) quality = (c % 600 == 0) ? 95 : ((c % 400 == 0) ? 10 : 50);
      reset_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 149) == 0) en = ~en;
      if ($urandom_range(0, 99) == 0) mode_mask = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0)
        timeout = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom_range(3, 40));
      done = ($urandom_range(0, 3) == 0);
      lock = ($urandom_range(0, 99) < quality);
      tick();
    end
    done = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pcma_lock_supervisor.md
Name: pcma_lock_supervisor

Overview:
- Sequences the PCMA detector chain: selects the modulation hypothesis, flushes the detector between hypotheses, counts per-measurement lock verdicts with confirm/loss hysteresis, and reports a qualified lock with its mode.
- Sits between the control registers and the detector. It drives the detector's mode input and an active-low detector reset. It consumes the detector's lock output and a one-cycle measurement-done pulse.

Parameters:
- CONFIRM_CNT, 3: consecutive lock verdicts needed to declare lock.
- LOSS_CNT, 4: consecutive no-lock verdicts in LOCKED needed to declare loss.
- HUNT_TRIES, 2: consecutive no-lock verdicts in HUNT before moving to the next mode.
- FLUSH_CYCLES, 8: clocks det_rst_n_o is held low per flush.
- TIMEOUT_WIDTH, 20: width of the watchdog counter.
- CNT_WIDTH, 4: width of the verdict counters. Must hold max(CONFIRM_CNT, LOSS_CNT, HUNT_TRIES).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- en_i  in  1  supervisor enable
- mode_mask_i  in  2  allowed modes: bit0 = fm4, bit1 = fm8
- timeout_i  in  TIMEOUT_WIDTH  maximum clocks between done pulses; 0 disables the watchdog
- det_done_i  in  1  one-cycle pulse when a detector verdict is ready
- det_lock_i  in  1  detector verdict, sampled only when det_done_i = 1
- det_mode_o  out  3  detector mode: 001 = fm4, 010 = fm8, 000 = none
- det_rst_n_o  out  1  detector reset, active-low
- locked_o  out  1  qualified lock
- locked_mode_o  out  3  mode valid while locked_o = 1, else 000
- busy_o  out  1  high in every state other than IDLE

Behaviour:
- Reset and clocking: reset_n is synchronous and active-low; clock is clk.
- Reset values: state = IDLE, det_mode_o = 000, det_rst_n_o = 0, locked_o = 0, locked_mode_o = 000, busy_o = 0, all counters = 0.
- All outputs are registered.
- Mode selection:
  - The hypothesis pointer cycles fm4 -> fm8 -> fm4, skipping modes not set in mode_mask_i.
  - If only one mask bit is set, that mode is reselected.
  - The mask is sampled on every mode advance.
- IDLE:
  - det_rst_n_o = 0.
  - When en_i = 1 and mode_mask_i != 0: go to FLUSH with the first allowed mode (fm4 preferred), latched into det_mode_o.
- FLUSH:
  - det_rst_n_o = 0 for exactly FLUSH_CYCLES clocks.
  - Then det_rst_n_o = 1, verdict counters and watchdog are cleared, and the block goes to HUNT.
  - det_done_i is ignored in FLUSH.
- HUNT, on det_done_i:
  - Lock verdict: clear the miss count and increment the confirm count. When it reaches CONFIRM_CNT, go to LOCKED, set locked_o = 1 and locked_mode_o = det_mode_o on the same edge.
  - No-lock verdict: clear the confirm count and increment the miss count. When it reaches HUNT_TRIES, advance the mode and go to FLUSH.
- LOCKED, on det_done_i:
  - Lock verdict: clear the loss count.
  - No-lock verdict: increment the loss count. When it reaches LOSS_CNT, clear locked_o and locked_mode_o, advance the mode, and go to FLUSH.
  - The detector is not reset while in LOCKED.
- Watchdog:
  - In HUNT and LOCKED, counts clocks since the last det_done_i.
  - Reaching timeout_i (nonzero) counts as a no-lock verdict and restarts the watchdog.
  - A done pulse on the same cycle as expiry takes precedence; the expiry is discarded.
- en_i deasserted in any state: go to IDLE next cycle, clear locked_o and locked_mode_o, det_rst_n_o = 0.
- mode_mask_i = 0 while not IDLE: treated as en_i = 0.
- Reset mid-operation returns all outputs to their reset values on that edge.
- Counters saturate and never wrap.
- Latency: det_done_i to locked_o change is 1 clock.

Optional Feature:
- Macro: PCMA_SUP_STATS_EN.
- Compiled in:
  - Adds output loss_cnt_o (16 bits), incremented on every LOCKED -> FLUSH transition and saturating at 0xFFFF.
  - Adds output hunt_cycles_o (16 bits), incremented per mode advance from HUNT, saturating.
  - Both clear on reset only.
- Compiled out: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package pcma_pkg holds:
  - mode encodings MODE_NONE = 3'b000, MODE_FM4 = 3'b001, MODE_FM8 = 3'b010;
  - the state enum (IDLE, FLUSH, HUNT, LOCKED);
  - mask bit indices.
- One natural sub-module: pcma_verdict_counter, a saturating hysteresis counter with clear, inc and threshold-hit outputs, instantiated for confirm, miss and loss.
- Watchdog and FSM stay in the top level.

Test Plan:
- Lock on fm4. Setup: mask = 11, CONFIRM_CNT = 3, en_i = 1. Stimulus: three det_done_i pulses with det_lock_i = 1. Required response: det_rst_n_o low for 8 clocks with det_mode_o = 001; locked_o = 1 and locked_mode_o = 001 one clock after the 3rd pulse.
- Hunt advance. Setup: mask = 11. Stimulus: two no-lock verdicts. Required response: FLUSH re-entered, det_mode_o = 010. Two more no-lock verdicts return det_mode_o to 001.
- Single mode. Setup: mask = 10. Stimulus: repeated no-lock verdicts. Required response: det_mode_o stays 010 through every flush and 001 never appears.
- Loss hysteresis. Setup: LOCKED on 010. Stimulus: 3 no-lock, 1 lock, 4 no-lock verdicts. Required response: locked_o stays 1 until the 4th consecutive miss, drops on the next clock, then det_mode_o = 001 in FLUSH.
- Watchdog. Setup: timeout_i = 100, in HUNT. Stimulus: no done pulses. Required response: a miss is counted at 100 clocks and FLUSH follows at 200 clocks. Setting timeout_i = 0 keeps the block in HUNT indefinitely.
- Disable / reset mid-operation. Stimulus: en_i = 0 in LOCKED, or reset_n = 0 in HUNT. Required response: next edge gives locked_o = 0, locked_mode_o = 000, det_rst_n_o = 0, busy_o = 0.
